frame_loader: RTL and testbench
===============================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter STRIPS, default 72: number of strip frame words held by the downstream strip store.
REQ-002 Parameter FRAME_LENGTH, default 16: width of one strip frame word and of the bus data path.
REQ-003 Parameter BANKS, default 4: number of bank idle flags.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port ne, input, 1: async bus chip-select, active low.
REQ-007 Port nwe, input, 1: async bus write strobe, active low.
REQ-008 Port addr, input, 2: bus register address; 0=STAT, 1=CTRL, 2=DATA, 3=RSV.
REQ-009 Port data_in, input, FRAME_LENGTH: bus write data; stable while nwe low.
REQ-010 Port idle, input, BANKS: per-bank idle flags from the LED banks.
REQ-011 Port rd_data, output, FRAME_LENGTH: registered read value for the addressed register.
REQ-012 Port wr_en, output, 1: one-cycle strobe writing wr_data into strip store at wr_addr.
REQ-013 Port wr_addr, output, clog2(STRIPS): strip index for the current wr_en.
REQ-014 Port wr_data, output, FRAME_LENGTH: frame word for the current wr_en.
REQ-015 Port go, output, 1: level start request to all LED banks.

Function
REQ-016 ne and nwe SHALL each pass through a 2-flop synchronizer; a third flop on nwe SHALL provide edge detection.
REQ-017 Capture: on the first clk where synchronized nwe is low with synchronized ne low, addr and data_in SHALL be latched into capture registers; bus write-low pulse is at least 3 clk periods.
REQ-018 Commit: on the synchronized nwe rising edge, with ne low at capture time, the captured write SHALL be decoded exactly once; writes with ne high SHALL be ignored.
REQ-019 FSM states IDLE -> CAPTURED (on capture) -> IDLE (on commit); a rising edge seen in IDLE SHALL be ignored.
REQ-020 CTRL write: go <= data bit0; bit0=1 SHALL reset strip index to 0; bit1=1 SHALL clear the err flag.
REQ-021 DATA write, accepted: wr_en=1 for exactly one clk, wr_addr=strip index, wr_data=captured word; then index increments.
REQ-022 Strip index SHALL wrap from STRIPS-1 to 0.
REQ-023 DATA write while go=1 and not all idle bits set SHALL be dropped (no wr_en, index unchanged) and SHALL set sticky err.
REQ-024 STAT/RSV writes SHALL have no effect.
REQ-025 wr_en SHALL rise on the 4th clk edge after nwe rises at the pin (2 sync, 1 edge detect, 1 output register).
REQ-026 rd_data SHALL be registered every clk from addr: STAT = {err at bit BANKS, idle in bits BANKS-1:0, zeros above}; CTRL = {zeros, go}; DATA = {zeros, strip index}; RSV = 0.
REQ-027 Coincident CTRL go=1 commit and index update SHALL leave index 0; only one commit can occur per clk.

Reset
REQ-028 While reset is high: go=0, wr_en=0, wr_addr=0, wr_data=0, rd_data=0, err=0, strip index=0, FSM=IDLE, synchronizers=1 (bus idle).
REQ-029 Reset asserted mid-write (state CAPTURED) SHALL abandon the write; the following nwe rising edge SHALL produce no wr_en.

Verification
REQ-030 Reset, then 3 DATA writes 0x1111/0x2222/0x3333 -> wr_en pulses with wr_addr 0,1,2 and matching wr_data; DATA read returns 3.
REQ-031 73 DATA writes -> write 72 goes to wr_addr 71, write 73 to wr_addr 0.
REQ-032 CTRL write 0x0001 with idle=4'b0111, then DATA write -> go=1, no wr_en, STAT reads 0x0017; CTRL write 0x0002 -> STAT reads 0x0007.
REQ-033 Write pulse with ne held high -> no wr_en, no go change, no index change.
REQ-034 Reset asserted between capture and nwe rising -> no wr_en, all outputs at reset values.
REQ-035 CTRL write 0x0001 after 5 DATA writes -> index 0; next accepted DATA write has wr_addr 0, and wr_en lands exactly 4 clk edges after nwe rises.

Source files
------------

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - async bus slave that loads strip frame words into the strip store
// Bus strobes are synchronized, captured on low, committed once on the nwe rising edge.
module frame_loader #(
    parameter int STRIPS       = 72,
    parameter int FRAME_LENGTH = 16,
    parameter int BANKS        = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ne,
    input  logic                              nwe,
    input  logic [1:0]                        addr,
    input  logic [FRAME_LENGTH-1:0]           data_in,
    input  logic [BANKS-1:0]                  idle,
    output logic [FRAME_LENGTH-1:0]           rd_data,
    output logic                              wr_en,
    output logic [$clog2(STRIPS)-1:0]         wr_addr,
    output logic [FRAME_LENGTH-1:0]           wr_data,
    output logic                              go
);
    localparam int IDX_W = $clog2(STRIPS);
    localparam logic [1:0] A_STAT = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_DATA = 2'd2;

    typedef enum logic {S_IDLE, S_CAPTURED} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    ne_s1, ne_s2;
    logic                    nwe_s1, nwe_s2, nwe_s3;
    logic                    rise_q;
    logic [1:0]              sync_valid;
    logic                    armed;
    logic                    capture;
    logic                    commit;
    logic [1:0]              cap_addr;
    logic [FRAME_LENGTH-1:0] cap_data;
    logic [IDX_W-1:0]        strip_idx;
    logic                    err;

    always_ff @(posedge clk) begin
        if (reset) begin
            ne_s1      <= 1'b1;
            ne_s2      <= 1'b1;
            nwe_s1     <= 1'b1;
            nwe_s2     <= 1'b1;
            nwe_s3     <= 1'b1;
            rise_q     <= 1'b0;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            ne_s1      <= ne;
            ne_s2      <= ne_s1;
            nwe_s1     <= nwe;
            nwe_s2     <= nwe_s1;
            nwe_s3     <= nwe_s2;
            rise_q     <= nwe_s2 & ~nwe_s3;
            sync_valid <= {sync_valid[0], 1'b1};
            // A strobe already low when reset released belongs to an abandoned write;
            // captures wait until the pin has really been seen high.
            armed      <= armed | (sync_valid[1] & nwe_s2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (capture) state_next = S_CAPTURED;
            S_CAPTURED: if (commit)  state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        commit  = 1'b0;
        case (state)
            S_IDLE:     capture = armed & ~ne_s2 & ~nwe_s2;
            S_CAPTURED: commit  = rise_q;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if (capture) begin
            cap_addr <= addr;
            cap_data <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go        <= 1'b0;
            err       <= 1'b0;
            strip_idx <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (commit) begin
                case (cap_addr)
                    A_CTRL: begin
                        go <= cap_data[0];
                        if (cap_data[0]) strip_idx <= '0;
                        if (cap_data[1]) err <= 1'b0;
                    end
                    A_DATA: begin
                        // Banks still scanning the old frame must not see their strips change.
                        if (go && !(&idle)) begin
                            err <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= strip_idx;
                            wr_data <= cap_data;
                            if (strip_idx == IDX_W'(STRIPS - 1)) strip_idx <= '0;
                            else                                 strip_idx <= strip_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= '0;
            case (addr)
                A_STAT: begin
                    rd_data[BANKS-1:0] <= idle;
                    rd_data[BANKS]     <= err;
                end
                A_CTRL:  rd_data[0]         <= go;
                A_DATA:  rd_data[IDX_W-1:0] <= strip_idx;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - scoreboard bench for frame_loader
module tb_frame_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ne = 1'b1;
    logic        nwe = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  idle = 4'b1111;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        go;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    logic [22:0] exp_q[$];

    frame_loader dut (
        .clk(clk), .reset(reset), .ne(ne), .nwe(nwe), .addr(addr),
        .data_in(data_in), .idle(idle), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .go(go)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every wr_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", {9'd0, wr_addr, wr_data}, 32'hFFFFFFFF);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {25'd0, wr_addr}, {25'd0, e[22:16]});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
                chk("latency", cyc - last_rise, 4);
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic ne_val);
        @(negedge clk);
        addr = a; data_in = d; ne = ne_val;
        @(negedge clk);
        nwe = 1'b0;
        repeat (4) @(negedge clk);
        nwe = 1'b1;
        last_rise = cyc;
        repeat (6) @(negedge clk);
        ne = 1'b1;
    endtask

    task automatic data_write(input logic [15:0] d, input logic [6:0] exp_addr);
        exp_q.push_back({exp_addr, d});
        bus_write(2'd2, d, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        chk(name, {16'd0, rd_data}, {16'd0, exp});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_go"}, {31'd0, go}, 0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
        chk({tag, "_wr_addr"}, {25'd0, wr_addr}, 0);
        chk({tag, "_wr_data"}, {16'd0, wr_data}, 0);
        chk({tag, "_rd_data"}, {16'd0, rd_data}, 0);
    endtask

    initial begin
        addr = 2'd2;
        repeat (5) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        data_write(16'h1111, 7'd0);
        data_write(16'h2222, 7'd1);
        data_write(16'h3333, 7'd2);
        rd(2'd2, 16'd3, "idx_after_3");

        data_write(16'h4444, 7'd3);
        data_write(16'h5555, 7'd4);
        bus_write(2'd1, 16'h0001, 1'b0);
        chk("go_set", {31'd0, go}, 1);
        rd(2'd2, 16'd0, "idx_after_ctrl");
        rd(2'd1, 16'd1, "ctrl_read");
        data_write(16'hA5A5, 7'd0);
        bus_write(2'd1, 16'h0000, 1'b0);
        chk("go_clear", {31'd0, go}, 0);

        bus_write(2'd1, 16'h0001, 1'b0);
        bus_write(2'd1, 16'h0000, 1'b0);
        for (int i = 0; i < 73; i++) begin
            logic [15:0] d;
            d = 16'h1000 + 16'(i);
            data_write(d, 7'(i % 72));
        end
        rd(2'd2, 16'd1, "idx_after_wrap");

        idle = 4'b0111;
        bus_write(2'd1, 16'h0001, 1'b0);
        bus_write(2'd2, 16'hBEEF, 1'b0);
        chk("go_busy", {31'd0, go}, 1);
        rd(2'd0, 16'h0017, "stat_err");
        rd(2'd2, 16'd0, "idx_dropped");
        bus_write(2'd1, 16'h0002, 1'b0);
        rd(2'd0, 16'h0007, "stat_err_clr");
        rd(2'd1, 16'd0, "ctrl_after_clr");

        data_write(16'h6666, 7'd0);
        bus_write(2'd2, 16'h5555, 1'b1);
        bus_write(2'd1, 16'h0001, 1'b1);
        chk("ne_high_go", {31'd0, go}, 0);
        rd(2'd2, 16'd1, "ne_high_idx");
        rd(2'd3, 16'd0, "rsv_read");

        idle = 4'b1111;
        bus_write(2'd1, 16'h0001, 1'b0);
        data_write(16'h7070, 7'd0);
        rd(2'd2, 16'd1, "idx_before_abort");
        @(negedge clk);
        addr = 2'd2; data_in = 16'h7777; ne = 1'b0;
        @(negedge clk);
        nwe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("abort");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        nwe = 1'b1;
        repeat (8) @(negedge clk);
        ne = 1'b1;
        rd(2'd2, 16'd0, "idx_after_abort");
        chk("go_after_abort", {31'd0, go}, 0);
        rd(2'd0, 16'h000F, "stat_after_abort");

        data_write(16'h9999, 7'd0);
        repeat (4) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
